// File: rtl/osd_dir_pkg.sv
// Shared types and constants for the OSD directory character store.
package osd_dir_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PAD   = 2'd2
  } dir_state_t;

  localparam logic [7:0] FILL_CHR_DEF = 8'h20;
  localparam logic [7:0] ERR_CHR_DEF  = 8'd66;

  // Each entry occupies a full power-of-two column stride in memory.
  function automatic int dir_mem_depth(input int max_entries, input int col_w);
    return max_entries * (1 << col_w);
  endfunction

endpackage

// File: rtl/osd_dir_ram.sv
// Simple dual-port 8-bit character RAM, one write port, one registered read port.
// Latency: read data valid one cycle after raddr; a same-address write returns old data.
// Backpressure: none, both ports accept every cycle.
module osd_dir_ram #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  // No reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/osd_dir_buffer.sv
// Directory-listing character store for the OSD; OSD_DIR_DOT_EN selects the 8.3 dotted read view.
// Latency: osd_dir_chr follows osd_dir_row/osd_dir_col by one cycle.
// Backpressure: wr_ready low while a clear or pad sweep runs and in the cycle clear is pulsed.
module osd_dir_buffer
  import osd_dir_pkg::*;
#(
  parameter int         MAX_ENTRIES = 32,
  parameter int         NAME_LEN    = 11,
  parameter int         ROW_W       = 8,
  parameter int         COL_W       = 4,
  parameter int         LEN_W       = 6,
  parameter logic [7:0] FILL_CHR    = FILL_CHR_DEF,
  parameter logic [7:0] ERR_CHR     = ERR_CHR_DEF
) (
  input  logic             clk32,
  input  logic             resb,
  input  logic             clear,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  input  logic             wr_last,
  output logic             busy,
  output logic             overflow,
  output logic [LEN_W-1:0] dir_len,
  input  logic [ROW_W-1:0] osd_dir_row,
  input  logic [COL_W-1:0] osd_dir_col,
  output logic [7:0]       osd_dir_chr
);

  localparam int DEPTH  = dir_mem_depth(MAX_ENTRIES, COL_W);
  localparam int ENT_W  = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1;
  localparam int ADDR_W = ENT_W + COL_W;
  localparam int CNT_W  = COL_W + 1;

  localparam logic [CNT_W-1:0]  NAME_LEN_C  = CNT_W'(NAME_LEN);
  localparam logic [CNT_W-1:0]  NAME_LAST_C = CNT_W'(NAME_LEN - 1);
  localparam logic [LEN_W-1:0]  MAX_C       = LEN_W'(MAX_ENTRIES);
  localparam logic [ADDR_W-1:0] CLR_LAST_C  = ADDR_W'(DEPTH - 1);

  dir_state_t        state_q;
  logic [CNT_W-1:0]  col_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              rdy_q;
  logic              busy_q;
  logic              ovf_q;

  logic              xfer;
  logic              full;
  logic              col_in;
  logic              last_pad;
  logic [ENT_W-1:0]  cur_ent;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;

  assign wr_ready = rdy_q && !clear;
  assign xfer     = wr_valid && wr_ready;
  assign full     = (len_q == MAX_C);
  assign col_in   = (col_q < NAME_LEN_C);
  assign last_pad = (col_q == NAME_LAST_C);
  assign cur_ent  = len_q[ENT_W-1:0];

  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign dir_len  = len_q;

  // Write port: sweep fill, loader byte, or pad fill into the entry being built.
  always_comb begin
    we    = 1'b0;
    waddr = clr_addr_q;
    wdata = FILL_CHR;
    if (!clear) begin
      case (state_q)
        ST_CLEAR: we = 1'b1;
        ST_LOAD: begin
          if (xfer && !full && col_in) begin
            we    = 1'b1;
            waddr = {cur_ent, col_q[COL_W-1:0]};
            wdata = wr_data;
          end
        end
        ST_PAD: begin
          we    = 1'b1;
          waddr = {cur_ent, col_q[COL_W-1:0]};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state_q    <= ST_CLEAR;
      col_q      <= '0;
      clr_addr_q <= '0;
      len_q      <= '0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b1;
      ovf_q      <= 1'b0;
    end else if (clear) begin
      state_q    <= ST_CLEAR;
      col_q      <= '0;
      clr_addr_q <= '0;
      len_q      <= '0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_addr_q == CLR_LAST_C) begin
            state_q    <= ST_LOAD;
            clr_addr_q <= '0;
            rdy_q      <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + ADDR_W'(1);
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            if (full) begin
              if (wr_last) begin
                ovf_q <= 1'b1;
              end
            end else if (wr_last) begin
              // Short name: pad from the next column before committing the entry.
              if (col_q < NAME_LAST_C) begin
                state_q <= ST_PAD;
                col_q   <= col_q + CNT_W'(1);
                rdy_q   <= 1'b0;
                busy_q  <= 1'b1;
              end else begin
                len_q <= len_q + LEN_W'(1);
                col_q <= '0;
              end
            end else if (col_in) begin
              col_q <= col_q + CNT_W'(1);
            end
          end
        end
        ST_PAD: begin
          if (last_pad) begin
            state_q <= ST_LOAD;
            len_q   <= len_q + LEN_W'(1);
            col_q   <= '0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            col_q <= col_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          rdy_q   <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef OSD_DIR_DOT_EN
  logic [MAX_ENTRIES-1:0] has_ext_q;

  // Flag tracks whatever lands in stored column 8, including pad fill.
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      has_ext_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      has_ext_q <= '0;
    end else if (we && (col_q == CNT_W'(8))) begin
      has_ext_q[cur_ent] <= (wdata != FILL_CHR);
    end
  end
`endif

  logic              err_d;
  logic [ENT_W-1:0]  rd_ent;
  logic [COL_W-1:0]  ram_col;
  logic              use_ram_d;
  logic [7:0]        const_d;
  logic              use_ram_q;
  logic [7:0]        const_q;
  logic [ADDR_W-1:0] raddr;
  logic [7:0]        ram_rdata;

  assign err_d  = (32'(osd_dir_row) >= 32'(len_q));
  assign rd_ent = osd_dir_row[ENT_W-1:0];
  assign raddr  = {rd_ent, ram_col};

  always_comb begin
    ram_col   = osd_dir_col;
    use_ram_d = 1'b0;
    const_d   = FILL_CHR;
    if (err_d) begin
      const_d = ERR_CHR;
`ifdef OSD_DIR_DOT_EN
    end else if (32'(osd_dir_col) < 8) begin
      use_ram_d = 1'b1;
    end else if (32'(osd_dir_col) == 8) begin
      const_d = has_ext_q[rd_ent] ? 8'h2E : FILL_CHR;
    end else if (32'(osd_dir_col) < 12) begin
      use_ram_d = 1'b1;
      ram_col   = osd_dir_col - COL_W'(1);
    end
`else
    end else if (32'(osd_dir_col) < NAME_LEN) begin
      use_ram_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      use_ram_q <= 1'b0;
      const_q   <= FILL_CHR;
    end else begin
      use_ram_q <= use_ram_d;
      const_q   <= const_d;
    end
  end

  assign osd_dir_chr = use_ram_q ? ram_rdata : const_q;

  osd_dir_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk32),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

endmodule
